// File: rtl/aes_mux_pkg.sv
// Shared definitions for the AES cipher request multiplexer: FSM states,
// request packing offsets and response error-bit position.
package aes_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DELIVER
   } state_e;

   localparam int OP_LSB    = 0;
   localparam int OP_W      = 2;
   localparam int STATE_LSB = 2;
   localparam int STATE_W   = 128;
   localparam int REQ_W     = OP_W + STATE_W;
   localparam int ERR_BIT   = 128;
   localparam int RES_W     = STATE_W + 1;

endpackage

// File: rtl/aes_ch_fifo.sv
// Per-channel request FIFO: power-of-two depth, wrapping pointers,
// combinational head output.
module aes_ch_fifo #(
   parameter int WIDTH = 130,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i)  rd_q <= rd_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/aes_cipher_mux_wrapper.sv
// Round-robin multiplexer sharing one AES cipher core among NUM_CH request
// channels, with per-channel FIFOs and a core-response timeout.
module aes_cipher_mux_wrapper
   import aes_mux_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_CH-1:0]       _ep_crypt_valid,
   output logic [NUM_CH-1:0]       _ep_crypt_ack,
   input  logic [NUM_CH*REQ_W-1:0] _ep_crypt_0,
   output logic [NUM_CH-1:0]       _ep_crypt_res_valid,
   input  logic [NUM_CH-1:0]       _ep_crypt_res_ack,
   output logic [RES_W-1:0]        _ep_crypt_res_0,
   output logic                    _core_req_valid,
   input  logic                    _core_req_ack,
   output logic [REQ_W-1:0]        _core_req_0,
   input  logic                    _core_res_valid,
   output logic                    _core_res_ack,
   input  logic [STATE_W-1:0]      _core_res_0
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int TW   = $clog2(TIMEOUT + 1);

   logic [NUM_CH-1:0] full, empty, push, pop;
   logic [REQ_W-1:0]  head [NUM_CH];

   state_e            state_q;
   logic [CH_W-1:0]   owner_q, rr_ptr_q, grant;
   logic              grant_vld;
   logic [REQ_W-1:0]  req_q;
   logic [STATE_W-1:0] res_q;
   logic              err_q, drop_q;
   logic [TW-1:0]     cnt_q;
   logic              res_take, timed_out;

   // Acks are forced low while reset is held so nothing is accepted into a clearing FIFO.
   assign _ep_crypt_ack = ~full & {NUM_CH{~rst_i}};
   assign push          = _ep_crypt_valid & _ep_crypt_ack;
   assign pop           = (state_q == ST_IDLE && grant_vld) ? (NUM_CH'(1) << grant) : '0;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      aes_ch_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push[c]),
         .data_i  (_ep_crypt_0[c*REQ_W +: REQ_W]),
         .pop_i   (pop[c]),
         .data_o  (head[c]),
         .full_o  (full[c]),
         .empty_o (empty[c])
      );
   end

   always_comb begin
      logic [CH_W:0]   sum;
      logic [CH_W-1:0] idx;
      grant     = rr_ptr_q;
      grant_vld = 1'b0;
      sum       = '0;
      idx       = '0;
      // Walk from the farthest offset back so the nearest non-empty channel wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
         if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
         idx = sum[CH_W-1:0];
         if (!empty[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

   // A result seen while a timed-out one is still owed belongs to the old request.
   assign res_take  = _core_res_valid && !drop_q;
   assign timed_out = (cnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (_core_res_valid && _core_res_ack && drop_q) drop_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_vld) begin
                  owner_q <= grant;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (_core_req_ack) begin
                  cnt_q   <= '0;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (res_take) begin
                  err_q   <= 1'b0;
                  state_q <= ST_DELIVER;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  drop_q  <= 1'b1;
                  state_q <= ST_DELIVER;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            ST_DELIVER: begin
               if (_ep_crypt_res_ack[owner_q]) begin
                  rr_ptr_q <= (owner_q == CH_W'(NUM_CH - 1)) ? '0 : owner_q + CH_W'(1);
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == ST_IDLE && grant_vld) req_q <= head[grant];
      if (state_q == ST_WAIT) begin
         if (res_take)       res_q <= _core_res_0;
         else if (timed_out) res_q <= '0;
      end
   end

   assign _core_req_valid = (state_q == ST_ISSUE);
   assign _core_req_0     = req_q;
   assign _core_res_ack   = (state_q == ST_WAIT) ||
                            (drop_q && (state_q == ST_IDLE || state_q == ST_ISSUE));
   assign _ep_crypt_res_valid = (state_q == ST_DELIVER) ? (NUM_CH'(1) << owner_q) : '0;
   assign _ep_crypt_res_0[ERR_BIT]       = err_q;
   assign _ep_crypt_res_0[STATE_W-1:0]   = res_q;

endmodule
